// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings for the data-memory access front end:
// funct3 memory data types, sequencer states and the misalign test.
package dmem_access_unit_pkg;

   localparam logic [2:0] MDT_B  = 3'b000;
   localparam logic [2:0] MDT_H  = 3'b001;
   localparam logic [2:0] MDT_W  = 3'b010;
   localparam logic [2:0] MDT_BU = 3'b100;
   localparam logic [2:0] MDT_HU = 3'b101;

   localparam logic [31:0] DATA_ZERO = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD1  = 3'd1,
      ST_WR0  = 3'd2,
      ST_WR1  = 3'd3,
      ST_DONE = 3'd4
   } dmem_state_e;

   function automatic logic is_misaligned(
      input logic [2:0] dt,
      input logic [1:0] off
   );
      logic r;
      r = 1'b0;
      case (dt)
         MDT_H, MDT_HU: r = off[0];
         MDT_W:         r = (off != 2'b00);
         default:       r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_access_unit_byte_align.sv
// Combinational 64-bit window logic: extract/extend a misaligned
// load and merge misaligned store bytes into the two covering words.
module dmem_byte_align
   import dmem_access_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] w0_i,
   input  logic [WIDTH-1:0] w1_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [1:0]       off_i,
   input  logic [2:0]       type_i,
   output logic [WIDTH-1:0] load_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);

   localparam int DW = 2 * WIDTH;

   logic [DW-1:0] pair;
   logic [DW-1:0] shifted;
   logic [DW-1:0] mask;
   logic [DW-1:0] ins;
   logic [DW-1:0] merged;
   logic [4:0]    sh;
   logic          is_half;
   logic          ext;

   always_comb begin
      is_half = (type_i == MDT_H) || (type_i == MDT_HU);
      pair    = {w1_i, w0_i};
      sh      = {off_i, 3'b000};
      shifted = pair >> sh;
      ext     = (type_i == MDT_HU) ? 1'b0 : shifted[15];
      load_o  = shifted[WIDTH-1:0];
      if (is_half) begin
         load_o = {{(WIDTH-16){ext}}, shifted[15:0]};
      end
      // Byte-lane mask covering the n bytes being stored.
      mask = '0;
      if (is_half) begin
         mask[15:0] = '1;
      end else begin
         mask[WIDTH-1:0] = '1;
      end
      mask = mask << sh;
      ins = '0;
      ins[WIDTH-1:0] = wdata_i;
      ins = ins << sh;
      merged = (pair & ~mask) | (ins & mask);
      lo_o   = merged[WIDTH-1:0];
      hi_o   = merged[DW-1:WIDTH];
   end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store front end to data memory. Define MISALIGN_SPLIT_EN to split
// misaligned H/W accesses into aligned words; otherwise they fault.
module dmem_access_unit
   import dmem_access_unit_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DMEM_DEPTH = 4096
) (
   input  logic             CPU_clk,
   input  logic             CPU_rst_n,
   input  logic             MemRead,
   input  logic             MemWrite,
   input  logic [2:0]       MemDataType,
   input  logic [WIDTH-1:0] ALUResult_Addr,
   input  logic [WIDTH-1:0] WriteData,
   output logic [WIDTH-1:0] ReadData,
   output logic             Stall,
   output logic             MisalignFault,
   output logic             dmem_MemRead,
   output logic             dmem_MemWrite,
   output logic [2:0]       dmem_MemDataType,
   output logic [WIDTH-1:0] dmem_Addr,
   output logic [WIDTH-1:0] dmem_WriteData,
   input  logic [WIDTH-1:0] dmem_ReadData
);

   // Dual requests and undefined types are never split or faulted.
   logic misalign;
   assign misalign = CPU_rst_n && (MemRead ^ MemWrite) &&
                     is_misaligned(MemDataType, ALUResult_Addr[1:0]);

`ifdef MISALIGN_SPLIT_EN

   localparam int BYTE_RANGE = $clog2(4 * DMEM_DEPTH);
   localparam logic [BYTE_RANGE-3:0] WIDX_ONE = 1;

   dmem_state_e state_q, state_d;

   logic [WIDTH-1:0]      w0_q, w0_d;
   logic [WIDTH-1:0]      w1_q, w1_d;
   logic [WIDTH-1:0]      a0, a1;
   logic [WIDTH-1:0]      load_data;
   logic [WIDTH-1:0]      mrg_lo, mrg_hi;
   logic [BYTE_RANGE-3:0] widx, widx_n;

   dmem_byte_align #(.WIDTH(WIDTH)) u_align (
      .w0_i    (w0_q),
      .w1_i    (w1_q),
      .wdata_i (WriteData),
      .off_i   (ALUResult_Addr[1:0]),
      .type_i  (MemDataType),
      .load_o  (load_data),
      .lo_o    (mrg_lo),
      .hi_o    (mrg_hi)
   );

   // Word index wraps inside the memory, so A1 of the last word is 0.
   always_comb begin
      widx   = ALUResult_Addr[BYTE_RANGE-1:2];
      widx_n = widx + WIDX_ONE;
      a0 = '0;
      a0[BYTE_RANGE-1:0] = {widx, 2'b00};
      a1 = '0;
      a1[BYTE_RANGE-1:0] = {widx_n, 2'b00};
   end

   always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
      if (!CPU_rst_n) begin
         state_q <= ST_IDLE;
         w0_q    <= '0;
         w1_q    <= '0;
      end else begin
         state_q <= state_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      w0_d             = w0_q;
      w1_d             = w1_q;
      dmem_MemRead     = MemRead;
      dmem_MemWrite    = MemWrite;
      dmem_MemDataType = MemDataType;
      dmem_Addr        = ALUResult_Addr;
      dmem_WriteData   = WriteData;
      ReadData         = dmem_ReadData;
      Stall            = 1'b0;
      MisalignFault    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (misalign) begin
               dmem_MemRead     = 1'b1;
               dmem_MemWrite    = 1'b0;
               dmem_MemDataType = MDT_W;
               dmem_Addr        = a0;
               Stall            = 1'b1;
               w0_d             = dmem_ReadData;
               state_d          = ST_RD1;
            end
         end
         ST_RD1: begin
            dmem_MemRead     = 1'b1;
            dmem_MemWrite    = 1'b0;
            dmem_MemDataType = MDT_W;
            dmem_Addr        = a1;
            Stall            = 1'b1;
            w1_d             = dmem_ReadData;
            state_d          = MemWrite ? ST_WR0 : ST_DONE;
         end
         ST_WR0: begin
            dmem_MemRead     = 1'b0;
            dmem_MemWrite    = 1'b1;
            dmem_MemDataType = MDT_W;
            dmem_Addr        = a0;
            dmem_WriteData   = mrg_lo;
            Stall            = 1'b1;
            state_d          = ST_WR1;
         end
         ST_WR1: begin
            dmem_MemRead     = 1'b0;
            dmem_MemWrite    = 1'b1;
            dmem_MemDataType = MDT_W;
            dmem_Addr        = a1;
            dmem_WriteData   = mrg_hi;
            Stall            = 1'b1;
            state_d          = ST_DONE;
         end
         ST_DONE: begin
            dmem_MemRead  = 1'b0;
            dmem_MemWrite = 1'b0;
            if (MemRead) begin
               ReadData = load_data;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`else

   logic unused_ok;
   assign unused_ok = &{1'b0, CPU_clk, DMEM_DEPTH[0]};

   always_comb begin
      dmem_MemRead     = MemRead;
      dmem_MemWrite    = MemWrite;
      dmem_MemDataType = MemDataType;
      dmem_Addr        = ALUResult_Addr;
      dmem_WriteData   = WriteData;
      ReadData         = dmem_ReadData;
      Stall            = 1'b0;
      MisalignFault    = 1'b0;
      if (misalign) begin
         MisalignFault = 1'b1;
         dmem_MemRead  = 1'b0;
         dmem_MemWrite = 1'b0;
         ReadData      = WIDTH'(DATA_ZERO);
      end
   end

`endif

endmodule
